// File: rtl/nios_debug_jtag_initiator.sv
// Virtual-JTAG initiator for the Nios II debug slave: one command = IR load + DR scan,
// with generated tck, state strobes and tdo capture.
module nios_debug_jtag_initiator #(
  parameter int DR_WIDTH   = 38,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(TCK_HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_DONE
  } state_t;

  state_t              state_q;
  logic                pend_q;
  logic [HW-1:0]       hcnt_q;
  logic [CW-1:0]       cnt_q;
  logic                tck_q, tdi_q, rti_q;
  logic                uir_q, cdr_q, sdr_q, udr_q;
  logic [1:0]          ir_q, cmd_ir_q;
  logic                rsp_valid_q;
  logic [DR_WIDTH-1:0] rsp_data_q, tx_q, rx_q;

  logic half_end, tck_rise, cyc_start;
  assign half_end  = (hcnt_q == HW'(TCK_HALF - 1));
  assign tck_rise  = half_end && !tck_q;
  assign cyc_start = half_end && tck_q;

  // The accept edge only latches the command; the first TCK cycle (UIR) starts
  // on the following clk edge, which accounts for the extra clk of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      hcnt_q      <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      rti_q       <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      ir_q        <= '0;
      cmd_ir_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && !rsp_valid_q) begin
            cmd_ir_q <= cmd_ir;
            tx_q     <= cmd_data;
            pend_q   <= 1'b1;
            state_q  <= S_UIR;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            hcnt_q <= '0;
            tck_q  <= 1'b0;
            ir_q   <= cmd_ir_q;
            uir_q  <= 1'b1;
            rti_q  <= 1'b0;
          end else if (tck_rise) begin
            tck_q  <= 1'b1;
            hcnt_q <= '0;
            if (state_q == S_SHIFT) rx_q <= {tdo, rx_q[DR_WIDTH-1:1]};
          end else if (cyc_start) begin
            tck_q  <= 1'b0;
            hcnt_q <= '0;
            case (state_q)
              S_UIR: begin
                state_q <= S_CDR;
                uir_q   <= 1'b0;
                cdr_q   <= 1'b1;
                tdi_q   <= tx_q[0];
              end
              S_CDR: begin
                state_q <= S_SHIFT;
                cdr_q   <= 1'b0;
                sdr_q   <= 1'b1;
                cnt_q   <= '0;
                tdi_q   <= tx_q[0];
                tx_q    <= tx_q >> 1;
              end
              S_SHIFT: begin
                if (cnt_q == CW'(DR_WIDTH - 1)) begin
                  state_q <= S_UDR;
                  sdr_q   <= 1'b0;
                  udr_q   <= 1'b1;
                  tdi_q   <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + CW'(1);
                  tdi_q <= tx_q[0];
                  tx_q  <= tx_q >> 1;
                end
              end
              S_UDR: begin
                state_q <= S_RTI;
                udr_q   <= 1'b0;
                rti_q   <= 1'b1;
                cnt_q   <= '0;
              end
              S_RTI: begin
                if (cnt_q == CW'(RTI_CYCLES - 1)) begin
                  state_q     <= S_DONE;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= rx_q;
                end else begin
                  cnt_q <= cnt_q + CW'(1);
                end
              end
              default: ;
            endcase
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign cmd_ready      = (state_q == S_IDLE) && !rsp_valid_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign tck            = tck_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_q;
  assign vs_uir         = uir_q;
  assign vs_cdr         = cdr_q;
  assign vs_sdr         = sdr_q;
  assign vs_udr         = udr_q;
  assign jtag_state_rti = rti_q;

endmodule

// File: tb/tb_nios_debug_jtag_initiator.sv
// Bench for nios_debug_jtag_initiator: DR loopback model on tdo, vector table plus
// back-pressure, mid-scan reset and a fast-TCK instance.
module tb_nios_debug_jtag_initiator;
  localparam int DW = 38;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1: defaults
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, tck, tdi, tdo;
  logic [1:0]    cmd_ir, ir_in;
  logic [DW-1:0] cmd_data, rsp_data;
  logic          vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

  nios_debug_jtag_initiator #(.DR_WIDTH(DW), .TCK_HALF(2), .RTI_CYCLES(2)) dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(rti));

  // Instance 2: fast tck, short RTI
  logic          cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, tck2, tdi2, tdo2;
  logic [1:0]    cmd_ir2, ir_in2;
  logic [DW-1:0] cmd_data2, rsp_data2;
  logic          vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, rti2;

  nios_debug_jtag_initiator #(.DR_WIDTH(DW), .TCK_HALF(1), .RTI_CYCLES(1)) dut2 (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_ir(cmd_ir2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_data(rsp_data2), .tck(tck2), .tdi(tdi2), .tdo(tdo2), .ir_in(ir_in2),
    .vs_uir(vs_uir2), .vs_cdr(vs_cdr2), .vs_sdr(vs_sdr2), .vs_udr(vs_udr2),
    .jtag_state_rti(rti2));

  // Loopback DR models: shift on tck rise during shift-DR, tdo = LSB
  logic [DW-1:0] sr1, sr2, pre1, pre2;
  logic          ld1 = 1'b0, ld2 = 1'b0;
  assign tdo  = sr1[0];
  assign tdo2 = sr2[0];
  always @(posedge tck or posedge ld1)
    if (ld1) sr1 <= pre1;
    else if (vs_sdr) sr1 <= {tdi, sr1[DW-1:1]};
  always @(posedge tck2 or posedge ld2)
    if (ld2) sr2 <= pre2;
    else if (vs_sdr2) sr2 <= {tdi2, sr2[DW-1:1]};

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor for instance 1
  logic mon = 1'b0;
  int c_uir, c_cdr, c_sdr, c_udr, c_rti, c_rise, c_excl, c_order, prev_id, id;
  always @(negedge clk) if (mon) begin
    c_uir += int'(vs_uir);
    c_cdr += int'(vs_cdr);
    c_sdr += int'(vs_sdr);
    c_udr += int'(vs_udr);
    c_rti += int'(rti);
    if ((int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(rti)) != 1) c_excl++;
    id = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : rti ? 5 : 0;
    if (id < prev_id) c_order++;
    prev_id = id;
  end
  always @(posedge tck) if (mon) c_rise++;

  typedef struct {
    logic [1:0]    ir;
    logic [DW-1:0] data;
    logic [DW-1:0] pre;
    logic [DW-1:0] exp_rsp;
  } vec_t;
  vec_t vecs[4];

  int lat;

  // Issue one command on instance 1 (entered #1 after a posedge) and wait for rsp_valid.
  task automatic run1(input logic [1:0] ir, input logic [DW-1:0] d, input logic [DW-1:0] pre,
                      input logic rdy);
    pre1 = pre; ld1 = 1'b1; #1 ld1 = 1'b0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
    c_rise = 0; c_excl = 0; c_order = 0; prev_id = 0;
    chk("cmd_ready_before", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_data = d; rsp_ready = rdy;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = ~d; cmd_ir = ~ir;
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) mon = 1'b1;
    end
    mon = 1'b0;
    chk("latency", 64'(lat), 64'd173);
  endtask

  logic [DW-1:0] hold_data;
  int unstable;

  initial begin
    vecs[0] = '{2'b01, 38'h2A_5A5A_A5A5, 38'h15_0000_FFFF, 38'h15_0000_FFFF};
    vecs[1] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000};
    vecs[2] = '{2'b00, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF};
    vecs[3] = '{2'b10, 38'h00_0000_0001, 38'h20_0000_0000, 38'h20_0000_0000};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b1;
    cmd_valid2 = 1'b0; cmd_ir2 = '0; cmd_data2 = '0; rsp_ready2 = 1'b1;
    pre1 = '0; pre2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_ir_in", 64'(ir_in), 64'd0);
    chk("rst_rti", 64'(rti), 64'd1);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);

    // Vector table with rsp_ready already high
    for (int unsigned i = 0; i < 4; i++) begin
      run1(vecs[i].ir, vecs[i].data, vecs[i].pre, 1'b1);
      chk("rsp_data", 64'(rsp_data), 64'(vecs[i].exp_rsp));
      chk("tdi_bits", 64'(sr1), 64'(vecs[i].data));
      chk("ir_in", 64'(ir_in), 64'(vecs[i].ir));
      chk("uir_clks", 64'(c_uir), 64'd4);
      chk("cdr_clks", 64'(c_cdr), 64'd4);
      chk("sdr_clks", 64'(c_sdr), 64'd152);
      chk("udr_clks", 64'(c_udr), 64'd4);
      chk("rti_clks", 64'(c_rti), 64'd8);
      chk("tck_rises", 64'(c_rise), 64'd43);
      chk("strobe_excl", 64'(c_excl), 64'd0);
      chk("strobe_order", 64'(c_order), 64'd0);
      @(posedge clk); #1;
      chk("rsp_cleared", 64'(rsp_valid), 64'd0);
      chk("ready_again", 64'(cmd_ready), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("ir_in_held", 64'(ir_in), 64'(vecs[i].ir));
      chk("tck_idle", 64'(tck), 64'd0);
    end

    // Back-pressure: response held, new command ignored
    run1(2'b01, 38'h12_3456_789A, 38'h0A_BCDE_F012, 1'b0);
    chk("bp_rsp_data", 64'(rsp_data), 64'h0A_BCDE_F012);
    hold_data = rsp_data;
    unstable = 0;
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = 38'h3F_0000_0000;
    for (int unsigned i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== hold_data || cmd_ready || vs_uir) unstable++;
    end
    chk("bp_stable", 64'(unstable), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rsp_cleared", 64'(rsp_valid), 64'd0);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("bp_ignored_ir", 64'(ir_in), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_scan", 64'({vs_uir, vs_cdr, vs_sdr}), 64'd0);

    // Reset during shift of bit 20
    pre1 = 38'h11_1111_1111; ld1 = 1'b1; #1 ld1 = 1'b0;
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = 38'h2B_CDEF_0123;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (90) @(posedge clk);
    #1;
    chk("mid_shift", 64'(vs_sdr), 64'd1);
    rst = 1'b1; #1;
    chk("mrst_tck", 64'(tck), 64'd0);
    chk("mrst_tdi", 64'(tdi), 64'd0);
    chk("mrst_ir_in", 64'(ir_in), 64'd0);
    chk("mrst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
    chk("mrst_rti", 64'(rti), 64'd1);
    chk("mrst_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ready", 64'(cmd_ready), 64'd1);
    run1(2'b10, 38'h1E_F00D_CAFE, 38'h25_A5A5_5A5A, 1'b1);
    chk("post_rst_data", 64'(rsp_data), 64'h25_A5A5_5A5A);
    chk("post_rst_tdi", 64'(sr1), 64'h1E_F00D_CAFE);
    chk("post_rst_ir", 64'(ir_in), 64'd2);
    @(posedge clk); #1;

    // Instance 2: TCK_HALF=1, RTI_CYCLES=1
    pre2 = 38'h33_C3C3_3C3C; ld2 = 1'b1; #1 ld2 = 1'b0;
    chk("d2_ready", 64'(cmd_ready2), 64'd1);
    cmd_valid2 = 1'b1; cmd_ir2 = 2'b01; cmd_data2 = 38'h0C_7777_8888;
    @(posedge clk); #1;
    cmd_valid2 = 1'b0; cmd_data2 = '0;
    lat = 0;
    while (!rsp_valid2 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d2_latency", 64'(lat), 64'd85);
    chk("d2_rsp_data", 64'(rsp_data2), 64'h33_C3C3_3C3C);
    chk("d2_tdi_bits", 64'(sr2), 64'h0C_7777_8888);
    chk("d2_ir_in", 64'(ir_in2), 64'd1);
    @(posedge clk); #1;
    chk("d2_cleared", 64'(rsp_valid2), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
